// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if: control/status bundle between the LED pattern state machine
// and the LED fade/PWM output stage.
//   enable     : run fading and LED drive (0 = frozen and dark)
//   pattern_in : per-LED on/off request
//   max_level  : brightness target for LEDs that are requested on
//   LED        : registered PWM drive to the board LEDs
//   busy       : registered, 1 while any channel is still fading
// master drives the requests, slave is the fade/PWM block.
interface led_fade_pwm_if;
    logic       enable;
    logic [7:0] pattern_in;
    logic [7:0] max_level;
    logic [7:0] LED;
    logic       busy;

    modport master (
        output enable,
        output pattern_in,
        output max_level,
        input  LED,
        input  busy
    );

    modport slave (
        input  enable,
        input  pattern_in,
        input  max_level,
        output LED,
        output busy
    );
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: drives eight LEDs by PWM, ramping each LED's brightness linearly
// toward its on/off target so pattern changes show up as smooth fades.
// All state runs on CLOCK_50; the ramp rate comes from a clock-enable divider.
//   CLOCK_50 : system clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : slave side of led_fade_pwm_if (enable, pattern_in, max_level in;
//              LED, busy out)
// Parameters:
//   RAMP_DIV : CLOCK_50 cycles per ramp tick (>= 2)
//   STEP     : level change per ramp tick (1..255)
module led_fade_pwm #(
    parameter int unsigned RAMP_DIV = 48828,
    parameter int unsigned STEP     = 1
) (
    input logic           CLOCK_50,
    input logic           RESET_N,
    led_fade_pwm_if.slave bus
);

    localparam int unsigned     DivW    = $clog2(RAMP_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(RAMP_DIV - 1);
    localparam logic [8:0]      Step9   = 9'(STEP);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]      pwm_cnt_q;
    logic [7:0]      level_q  [8];
    logic [7:0]      level_d  [8];
    logic [7:0]      target_q [8];
    logic [7:0]      target_d [8];
    logic [7:0]      led_q, led_d;
    logic            busy_q, busy_d;
    logic            tick;
    logic [8:0]      up_sum   [8];
    logic [8:0]      dn_diff  [8];

    always_comb begin
        tick      = bus.enable && (div_cnt_q == DivLast);
        div_cnt_d = div_cnt_q;
        if (bus.enable) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
        end

        led_d  = '0;
        busy_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            target_d[i] = bus.pattern_in[i] ? bus.max_level : 8'h00;
            led_d[i]    = bus.enable && (level_q[i] > pwm_cnt_q);
            busy_d      = busy_d | (level_q[i] != target_q[i]);

            // 9-bit arithmetic: carry/borrow in bit 8 means overshoot, clamp to target.
            up_sum[i]  = {1'b0, level_q[i]} + Step9;
            dn_diff[i] = {1'b0, level_q[i]} - Step9;

            level_d[i] = level_q[i];
            if (tick) begin
                if (level_q[i] < target_q[i]) begin
                    level_d[i] = (up_sum[i] > {1'b0, target_q[i]}) ? target_q[i]
                                                                    : up_sum[i][7:0];
                end else if (level_q[i] > target_q[i]) begin
                    level_d[i] = (dn_diff[i][8] || (dn_diff[i][7:0] < target_q[i]))
                                 ? target_q[i] : dn_diff[i][7:0];
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt_q <= '0;
            pwm_cnt_q <= 8'h00;
            led_q     <= 8'h00;
            busy_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                level_q[i]  <= 8'h00;
                target_q[i] <= 8'h00;
            end
        end else begin
            div_cnt_q <= div_cnt_d;
            // Free-running regardless of enable so the PWM period never stretches.
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            led_q     <= led_d;
            busy_q    <= busy_d;
            for (int i = 0; i < 8; i++) begin
                level_q[i]  <= level_d[i];
                target_q[i] <= target_d[i];
            end
        end
    end

    assign bus.LED  = led_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: two instances (STEP=1 and STEP=100, RAMP_DIV=4) share
// stimulus; outputs are compared every cycle with a behavioural model, plus
// directed checks on reset, busy timing and PWM duty.
module tb_led_fade_pwm;

    localparam int RampDiv = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic [7:0] pat   = 8'hFF;
    logic [7:0] maxl  = 8'h80;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_fade_pwm_if bus_a ();
    led_fade_pwm_if bus_b ();

    assign bus_a.enable     = en;
    assign bus_a.pattern_in = pat;
    assign bus_a.max_level  = maxl;
    assign bus_b.enable     = en;
    assign bus_b.pattern_in = pat;
    assign bus_b.max_level  = maxl;

    led_fade_pwm #(.RAMP_DIV(RampDiv), .STEP(1)) dut_a (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus_a)
    );

    led_fade_pwm #(.RAMP_DIV(RampDiv), .STEP(100)) dut_b (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus_b)
    );

    // Behavioural model: plain integer levels/targets, ticks every RampDiv enabled cycles.
    int       m_tgt [2][8];
    int       m_lvl [2][8];
    int       m_div [2];
    int       m_pwm [2];
    bit [7:0] m_led [2];
    bit       m_busy[2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_div[k]  = 0;
            m_pwm[k]  = 0;
            m_led[k]  = 8'h00;
            m_busy[k] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_tgt[k][i] = 0;
                m_lvl[k][i] = 0;
            end
        end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            int st;
            bit tick;
            bit diff;
            st   = (k == 0) ? 1 : 100;
            tick = en && (m_div[k] == RampDiv - 1);
            diff = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_led[k][i] = en && (m_lvl[k][i] > m_pwm[k]);
                if (m_lvl[k][i] != m_tgt[k][i]) diff = 1'b1;
                if (tick) begin
                    if (m_lvl[k][i] < m_tgt[k][i]) begin
                        m_lvl[k][i] = (m_lvl[k][i] + st > m_tgt[k][i]) ? m_tgt[k][i]
                                                                        : m_lvl[k][i] + st;
                    end else if (m_lvl[k][i] > m_tgt[k][i]) begin
                        m_lvl[k][i] = (m_lvl[k][i] - st < m_tgt[k][i]) ? m_tgt[k][i]
                                                                        : m_lvl[k][i] - st;
                    end
                end
                m_tgt[k][i] = pat[i] ? int'(maxl) : 0;
            end
            m_busy[k] = diff;
            if (en) m_div[k] = (m_div[k] + 1) % RampDiv;
            m_pwm[k] = (m_pwm[k] + 1) % 256;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check_eq("led_a",  {24'h0, bus_a.LED},  {24'h0, m_led[0]});
            check_eq("busy_a", {31'h0, bus_a.busy}, {31'h0, m_busy[0]});
            check_eq("led_b",  {24'h0, bus_b.LED},  {24'h0, m_led[1]});
            check_eq("busy_b", {31'h0, bus_b.busy}, {31'h0, m_busy[1]});
        end
    endtask

    int cnt_a [8];
    int cnt_b [8];

    initial begin
        // Reset held with an active request pending.
        repeat (3) @(negedge clk);
        check_eq("rst_led_a",  {24'h0, bus_a.LED},  32'h0);
        check_eq("rst_busy_a", {31'h0, bus_a.busy}, 32'h0);
        check_eq("rst_led_b",  {24'h0, bus_b.LED},  32'h0);
        check_eq("rst_busy_b", {31'h0, bus_b.busy}, 32'h0);
        rst_n = 1'b1;
        run(2);
        check_eq("busy_rise", {31'h0, bus_a.busy}, 32'h1);
        run(600);
        check_eq("settle_80_busy", {31'h0, bus_a.busy}, 32'h0);

        // Fade down to 0x40 on all channels, then measure one PWM period.
        maxl = 8'h40;
        run(300);
        for (int i = 0; i < 8; i++) begin
            cnt_a[i] = 0;
            cnt_b[i] = 0;
        end
        for (int c = 0; c < 256; c++) begin
            run(1);
            for (int i = 0; i < 8; i++) begin
                cnt_a[i] += int'(bus_a.LED[i]);
                cnt_b[i] += int'(bus_b.LED[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("duty_a%0d", i), cnt_a[i], 64);
            check_eq($sformatf("duty_b%0d", i), cnt_b[i], 64);
        end

        // Swap halves at full brightness.
        pat  = 8'h0F;
        maxl = 8'hFF;
        run(1100);
        pat = 8'hF0;
        run(1000);
        check_eq("swap_busy_mid", {31'h0, bus_a.busy}, 32'h1);
        run(40);
        check_eq("swap_busy_end", {31'h0, bus_a.busy}, 32'h0);

        // Large-step ramp 0 -> FA and back down.
        pat = 8'h00;
        run(1100);
        pat  = 8'hFF;
        maxl = 8'hFA;
        run(40);
        pat = 8'h00;
        run(40);

        // Freeze mid-ramp.
        pat  = 8'hFF;
        maxl = 8'hC0;
        run(100);
        en = 1'b0;
        run(1);
        for (int c = 0; c < 49; c++) begin
            run(1);
            if (c % 10 == 0) check_eq("frozen_dark", {24'h0, bus_a.LED}, 32'h0);
        end
        en = 1'b1;
        run(200);

        // Redirect toward a lower max_level mid-ramp.
        maxl = 8'h20;
        run(400);
        check_eq("redirect_busy", {31'h0, bus_a.busy}, 32'h0);

        // Randomized requests.
        for (int seg = 0; seg < 80; seg++) begin
            pat  = 8'($urandom);
            maxl = 8'($urandom);
            en   = ($urandom_range(0, 4) != 0);
            run(int'($urandom_range(1, 60)));
        end
        en = 1'b1;
        pat  = 8'hFF;
        maxl = 8'hFF;
        run(300);

        // Asynchronous reset mid-ramp, away from any clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_led_a",  {24'h0, bus_a.LED},  32'h0);
        check_eq("arst_busy_a", {31'h0, bus_a.busy}, 32'h0);
        check_eq("arst_led_b",  {24'h0, bus_b.LED},  32'h0);
        check_eq("arst_busy_b", {31'h0, bus_b.busy}, 32'h0);
        run(5);
        rst_n = 1'b1;
        run(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
